// File: rtl/spi_stream_tx_if.sv
// Handshake bundle for spi_stream_tx: command, memory-read and SPI byte-sender sides.
// The streamer uses the master modport; its environment uses the slave modport.
interface spi_stream_tx_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  logic              cmd_ready;
  logic              cmd_abort;
  logic [ADDR_W-1:0] region_begin;
  logic [ADDR_W-1:0] region_end;
  logic              cmd_busy;
  logic              cmd_done;
  logic              mem_avail;
  logic              mem_r_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;
  logic [DATA_W-1:0] mem_data;
  logic              busy;
  logic              write;
  logic [7:0]        byte_send;

  modport master (
    input  cmd_ready, cmd_abort, region_begin, region_end,
    input  mem_avail, mem_done, mem_data, busy,
    output cmd_busy, cmd_done, mem_r_en, mem_addr, write, byte_send
  );

  modport slave (
    output cmd_ready, cmd_abort, region_begin, region_end,
    output mem_avail, mem_done, mem_data, busy,
    input  cmd_busy, cmd_done, mem_r_en, mem_addr, write, byte_send
  );
endinterface

// File: rtl/spi_stream_tx.sv
// Streams a memory word region (optionally preceded by a 16-bit word count) into an SPI
// byte sender, one byte per strobe, with one-word read prefetch and command abort.
module spi_stream_tx #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter bit          MSB_FIRST = 1'b0,
  parameter bit          HDR_EN    = 1'b1
) (
  input logic             clk,
  input logic             rst_L,
  spi_stream_tx_if.master bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, HDR, RUN, FIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] end_q, fetch_ptr, addr_q, span;
  logic [15:0]       hdr_cnt;
  logic              hdr_idx;
  logic [DATA_W-1:0] pf_buf, sh_buf;
  logic              pf_full, sh_full;
  logic [IDX_W-1:0]  byte_idx, sel_k;
  logic              r_en_q, write_q;
  logic [7:0]        byte_q, byte_nxt;

  logic abort, start, issue, capture, load, strobe, last_byte;

  always_comb begin
    state_nxt = state;
    abort     = bus.cmd_abort && (state != IDLE);
    start     = (state == IDLE) && bus.cmd_ready;
    span      = bus.region_end - bus.region_begin;
    issue     = 1'b0;
    capture   = 1'b0;
    load      = 1'b0;
    strobe    = 1'b0;
    last_byte = (byte_idx == IDX_W'(NB - 1));
    sel_k     = MSB_FIRST ? (IDX_W'(NB - 1) - byte_idx) : byte_idx;
    byte_nxt  = '0;

    // Abort masks every engine action so it wins over a same-cycle mem_done or strobe.
    if ((state == HDR || state == RUN) && !abort) begin
      load    = (state == RUN) && !sh_full && pf_full;
      issue   = (!pf_full || load) && !r_en_q && (fetch_ptr != end_q) && bus.mem_avail;
      capture = r_en_q && bus.mem_done;
      strobe  = !bus.busy && !write_q && ((state == HDR) || sh_full);
    end

    if (state == HDR) byte_nxt = hdr_idx ? hdr_cnt[7:0] : hdr_cnt[15:8];
    else              byte_nxt = sh_buf[{sel_k, 3'b000} +: 8];

    case (state)
      IDLE:    if (start) state_nxt = HDR_EN ? HDR : RUN;
      HDR:     if (strobe && hdr_idx) state_nxt = RUN;
      RUN:     if ((fetch_ptr == end_q) && !r_en_q && !pf_full && !sh_full) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      end_q     <= '0;
      fetch_ptr <= '0;
      addr_q    <= '0;
      hdr_cnt   <= '0;
      hdr_idx   <= 1'b0;
      pf_buf    <= '0;
      sh_buf    <= '0;
      pf_full   <= 1'b0;
      sh_full   <= 1'b0;
      byte_idx  <= '0;
      r_en_q    <= 1'b0;
      write_q   <= 1'b0;
      byte_q    <= '0;
    end else begin
      write_q <= strobe;
      if (strobe) byte_q <= byte_nxt;
      if (abort) begin
        r_en_q  <= 1'b0;
        pf_full <= 1'b0;
        sh_full <= 1'b0;
      end else begin
        if (start) begin
          end_q     <= bus.region_end;
          fetch_ptr <= bus.region_begin;
          hdr_cnt   <= 16'(span);
          hdr_idx   <= 1'b0;
          byte_idx  <= '0;
        end
        if (issue) begin
          r_en_q <= 1'b1;
          addr_q <= fetch_ptr;
        end
        if (capture) begin
          r_en_q    <= 1'b0;
          pf_buf    <= bus.mem_data;
          fetch_ptr <= fetch_ptr + ADDR_W'(1);
        end
        if (load) begin
          sh_buf   <= pf_buf;
          byte_idx <= '0;
          sh_full  <= 1'b1;
        end
        // capture and load never coincide: a read is only outstanding while prefetch is empty.
        if (load)    pf_full <= 1'b0;
        if (capture) pf_full <= 1'b1;
        if (strobe) begin
          if (state == HDR)   hdr_idx  <= 1'b1;
          else if (last_byte) sh_full  <= 1'b0;
          else                byte_idx <= byte_idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.cmd_busy  = (state != IDLE);
  assign bus.cmd_done  = (state == FIN);
  assign bus.mem_r_en  = r_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.write     = write_q;
  assign bus.byte_send = byte_q;

endmodule
